// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: size/state encodings, registered request type and alignment helpers
package dmem_access_ctrl_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    localparam int DMEM_TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Size 2'b11 behaves as a word everywhere.
    function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == MEM_BYTE) ? 1'b0 : (size == MEM_HALF) ? off[0] : (off != 2'b00);
    endfunction

    // Offset with the bits a naturally aligned access cannot use forced to zero.
    function automatic logic [1:0] mem_align_off(input logic [1:0] size, input logic [1:0] off);
        return (size == MEM_BYTE) ? off : (size == MEM_HALF) ? {off[1], 1'b0} : 2'b00;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: EX request, response and data-SRAM signals of the access controller
interface dmem_access_ctrl_if;
    logic        i_req_valid;
    logic        i_req_we;
    logic [1:0]  i_req_size;
    logic        i_req_signed;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_stall_req;
    logic        o_resp_valid;
    logic [31:0] o_resp_rdata;
    logic        o_resp_timeout;
    logic        o_err_misalign;
    logic        o_sram_en;
    logic [3:0]  o_sram_wen;
    logic [31:0] o_sram_addr;
    logic [31:0] o_sram_wdata;
    logic [31:0] i_sram_rdata;
    logic        i_sram_ready;

    modport slave (
        input  i_req_valid, i_req_we, i_req_size, i_req_signed, i_req_addr, i_req_wdata,
        input  i_sram_rdata, i_sram_ready,
        output o_stall_req, o_resp_valid, o_resp_rdata, o_resp_timeout, o_err_misalign,
        output o_sram_en, o_sram_wen, o_sram_addr, o_sram_wdata
    );

    modport master (
        output i_req_valid, i_req_we, i_req_size, i_req_signed, i_req_addr, i_req_wdata,
        output i_sram_rdata, i_sram_ready,
        input  o_stall_req, o_resp_valid, o_resp_rdata, o_resp_timeout, o_err_misalign,
        input  o_sram_en, o_sram_wen, o_sram_addr, o_sram_wdata
    );
endinterface

// File: rtl/dmem_access_ctrl_lane_fmt.sv
// dmem_lane_fmt: little-endian byte-lane packing for stores and extraction/extension for loads
module dmem_lane_fmt
    import dmem_access_ctrl_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wen,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Offset is already aligned for the size, so half-word lanes only look at off[1].
    always_comb begin
        w_byte  = i_rdata[{i_off, 3'b000} +: 8];
        w_half  = i_rdata[{i_off[1], 4'b0000} +: 16];
        o_wen   = (i_size == MEM_BYTE) ? (4'b0001 << i_off) :
                  (i_size == MEM_HALF) ? (4'b0011 << {i_off[1], 1'b0}) : 4'b1111;
        o_wdata = (i_size == MEM_BYTE) ? {4{i_wdata[7:0]}} :
                  (i_size == MEM_HALF) ? {2{i_wdata[15:0]}} : i_wdata;
        o_rdata = (i_size == MEM_BYTE) ? {{24{i_signed & w_byte[7]}}, w_byte} :
                  (i_size == MEM_HALF) ? {{16{i_signed & w_half[15]}}, w_half} : i_rdata;
    end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: one-at-a-time data-SRAM access sequencer with timeout; define DMEM_ALIGN_CHECK_EN to reject misaligned requests
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = DMEM_TIMEOUT_DEFAULT
) (
    input logic               clk,
    input logic               rst,
    dmem_access_ctrl_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_t        r_state;
    state_t        w_next;
    req_t          r_req;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_rdata;
    logic          r_timeout;
    logic          r_err;
    logic          w_take;
    logic          w_mis;
    logic          w_cnt_last;
    logic [3:0]    w_wen;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rdata_ext;

    assign w_take     = (r_state == ST_IDLE) && bus.i_req_valid;
    assign w_cnt_last = (r_cnt == CW'(TIMEOUT_CYC - 1));

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_mis = mem_misaligned(bus.i_req_size, bus.i_req_addr[1:0]);
`else
    assign w_mis = 1'b0;
`endif

    dmem_lane_fmt u_lane_fmt (
        .i_size   (r_req.size),
        .i_off    (r_req.addr[1:0]),
        .i_signed (r_req.sgn),
        .i_wdata  (r_req.wdata),
        .i_rdata  (bus.i_sram_rdata),
        .o_wen    (w_wen),
        .o_wdata  (w_wdata),
        .o_rdata  (w_rdata_ext)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next state: rejected requests skip the SRAM; ready or timeout ends the access.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   w_next = bus.i_req_valid ? (w_mis ? ST_DONE : ST_ACCESS) : ST_IDLE;
            ST_ACCESS: w_next = (bus.i_sram_ready || w_cnt_last) ? ST_DONE : ST_ACCESS;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Capture the request with its offset aligned, then count waits and latch the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req     <= '0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_take) begin
            r_req     <= '{we: bus.i_req_we, size: bus.i_req_size, sgn: bus.i_req_signed,
                           addr: {bus.i_req_addr[31:2], mem_align_off(bus.i_req_size, bus.i_req_addr[1:0])},
                           wdata: bus.i_req_wdata};
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
            r_err     <= w_mis;
        end else if (r_state == ST_ACCESS) begin
            if (bus.i_sram_ready) r_rdata   <= r_req.we ? 32'd0 : w_rdata_ext;
            else if (w_cnt_last)  r_timeout <= 1'b1;
            else                  r_cnt     <= r_cnt + CW'(1);
        end
    end

    assign bus.o_stall_req    = w_take || (r_state == ST_ACCESS);
    assign bus.o_resp_valid   = (r_state == ST_DONE);
    assign bus.o_resp_rdata   = (r_state == ST_DONE) ? r_rdata : 32'd0;
    assign bus.o_resp_timeout = (r_state == ST_DONE) && r_timeout;
    assign bus.o_err_misalign = (r_state == ST_DONE) && r_err;
    assign bus.o_sram_en      = (r_state == ST_ACCESS);
    assign bus.o_sram_wen     = (r_state == ST_ACCESS && r_req.we) ? w_wen : 4'b0000;
    assign bus.o_sram_addr    = (r_state == ST_ACCESS) ? {r_req.addr[31:2], 2'b00} : 32'd0;
    assign bus.o_sram_wdata   = (r_state == ST_ACCESS) ? w_wdata : 32'd0;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: randomized scoreboard bench for dmem_access_ctrl (honours DMEM_ALIGN_CHECK_EN)
module tb_dmem_access_ctrl;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_access_ctrl_if bus ();

    dmem_access_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int unsigned cyc;
        logic        we;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_exp_t;

    typedef struct {
        int unsigned cyc;
        logic [31:0] rdata;
        logic        to;
        logic        err;
    } resp_exp_t;

    sram_exp_t sq[$];
    resp_exp_t rq[$];
    sram_exp_t se_m;
    resp_exp_t re_m;
    logic      prev_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ext(input logic [31:0] v, input int bits, input logic sgn);
        logic [31:0] m;
        m = (32'd1 << bits) - 32'd1;
        v = v & m;
        if (sgn && ((v >> (bits - 1)) & 32'd1) != 0) v = v | ~m;
        return v;
    endfunction

    // Monitor: pops expectations when an access starts or a response appears.
    always @(posedge clk) begin
        #1;
        if (bus.o_sram_en && !prev_en) begin
            if (sq.size() == 0) chk("sram_unexpected", 32'd1, 32'd0);
            else begin
                se_m = sq.pop_front();
                chk("sram_cyc", cyc, se_m.cyc);
                chk("sram_wen", {28'd0, bus.o_sram_wen}, {28'd0, se_m.wen});
                chk("sram_addr", bus.o_sram_addr, se_m.addr);
                if (se_m.we) chk("sram_wdata", bus.o_sram_wdata, se_m.wdata);
                chk("stall_access", {31'd0, bus.o_stall_req}, 32'd1);
            end
        end
        prev_en = bus.o_sram_en;
        if (bus.o_resp_valid) begin
            if (rq.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
            else begin
                re_m = rq.pop_front();
                chk("resp_cyc", cyc, re_m.cyc);
                chk("resp_rdata", bus.o_resp_rdata, re_m.rdata);
                chk("resp_timeout", {31'd0, bus.o_resp_timeout}, {31'd0, re_m.to});
                chk("err_misalign", {31'd0, bus.o_err_misalign}, {31'd0, re_m.err});
                chk("stall_done", {31'd0, bus.o_stall_req}, 32'd0);
                chk("sram_en_done", {31'd0, bus.o_sram_en}, 32'd0);
            end
        end
    end

    task automatic idle_cycle();
        @(negedge clk);
        bus.i_req_valid  = 1'b0;
        bus.i_sram_ready = 1'($urandom_range(0, 1));
        bus.i_sram_rdata = $urandom;
    endtask

    // One transaction: drive it, predict it, play the SRAM with k wait cycles.
    task automatic txn(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd, input int k);
        int unsigned o, n, c;
        logic        err, mis;
        sram_exp_t   se;
        resp_exp_t   re;
        o   = addr[1:0];
        mis = (sz == 2'd1 && o % 2 == 1) || (sz >= 2'd2 && o != 0);
        err = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        err = mis;
`endif
        if (sz == 2'd1) o = o & 2;
        else if (sz >= 2'd2) o = 0;
        n = err ? 0 : (k >= TO ? TO : k + 1);
        @(negedge clk);
        c = cyc;
        bus.i_req_valid  = 1'b1;
        bus.i_req_we     = we;
        bus.i_req_size   = sz;
        bus.i_req_signed = sgn;
        bus.i_req_addr   = addr;
        bus.i_req_wdata  = wd;
        bus.i_sram_ready = 1'($urandom_range(0, 1));
        bus.i_sram_rdata = $urandom;
        if (!err) begin
            se.cyc   = c + 1;
            se.we    = we;
            se.wen   = !we ? 4'd0 : sz == 2'd0 ? 4'(1 << o) : sz == 2'd1 ? 4'(3 << o) : 4'd15;
            se.addr  = addr & ~32'd3;
            se.wdata = sz == 2'd0 ? (wd & 32'hFF) * 32'h01010101 :
                       sz == 2'd1 ? (wd & 32'hFFFF) * 32'h00010001 : wd;
            sq.push_back(se);
        end
        re.cyc   = c + 1 + n;
        re.err   = err;
        re.to    = !err && k >= TO;
        re.rdata = (err || re.to || we) ? 32'd0 :
                   sz == 2'd0 ? ext(rd >> (8 * o), 8, sgn) :
                   sz == 2'd1 ? ext(rd >> (8 * o), 16, sgn) : rd;
        rq.push_back(re);
        #1;
        chk("stall_idle_req", {31'd0, bus.o_stall_req}, 32'd1);
        for (int i = 0; i < int'(n); i++) begin
            @(negedge clk);
            bus.i_req_valid  = 1'b0;
            bus.i_sram_ready = (k < TO && i == k);
            bus.i_sram_rdata = (i == k) ? rd : $urandom;
        end
        @(negedge clk);
        bus.i_req_valid  = 1'b1;
        bus.i_req_we     = 1'($urandom_range(0, 1));
        bus.i_req_size   = 2'($urandom_range(0, 3));
        bus.i_req_addr   = $urandom;
        bus.i_req_wdata  = $urandom;
        bus.i_sram_ready = 1'($urandom_range(0, 1));
        bus.i_sram_rdata = $urandom;
    endtask

    initial begin
        int          k, c;
        logic [31:0] a;
        bus.i_req_valid  = 1'b0;
        bus.i_req_we     = 1'b0;
        bus.i_req_size   = 2'd0;
        bus.i_req_signed = 1'b0;
        bus.i_req_addr   = 32'd0;
        bus.i_req_wdata  = 32'd0;
        bus.i_sram_rdata = 32'd0;
        bus.i_sram_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, bus.o_stall_req}, 32'd0);
        chk("rst_resp_valid", {31'd0, bus.o_resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus.o_resp_rdata, 32'd0);
        chk("rst_timeout", {31'd0, bus.o_resp_timeout}, 32'd0);
        chk("rst_err", {31'd0, bus.o_err_misalign}, 32'd0);
        chk("rst_sram_en", {31'd0, bus.o_sram_en}, 32'd0);
        chk("rst_sram_wen", {28'd0, bus.o_sram_wen}, 32'd0);
        chk("rst_sram_addr", bus.o_sram_addr, 32'd0);
        chk("rst_sram_wdata", bus.o_sram_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        txn(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        txn(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5, 32'h0, 1);
        txn(1'b1, 2'd1, 1'b0, 32'h102, 32'h00001234, 32'h0, 2);
        txn(1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 32'h00008000, 0);
        txn(1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 32'h00008000, 3);
        txn(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'hFFFE0000, 1);
        txn(1'b0, 2'd3, 1'b0, 32'h104, 32'h0, 32'hCAFEF00D, 0);
        txn(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h12345678, TO - 1);
        txn(1'b0, 2'd2, 1'b0, 32'h204, 32'h0, 32'h12345678, 40);
        txn(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h87654321, 0);
        txn(1'b1, 2'd1, 1'b0, 32'h301, 32'h0000BEEF, 32'h0, 0);

        // Reset three waits into an access: bus must go quiet and no response may appear.
        @(negedge clk);
        c = cyc;
        bus.i_req_valid  = 1'b1;
        bus.i_req_we     = 1'b0;
        bus.i_req_size   = 2'd2;
        bus.i_req_addr   = 32'h400;
        bus.i_sram_ready = 1'b0;
        sq.push_back('{cyc: c + 1, we: 1'b0, wen: 4'd0, addr: 32'h400, wdata: 32'd0});
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_sram_en", {31'd0, bus.o_sram_en}, 32'd0);
        chk("midrst_stall", {31'd0, bus.o_stall_req}, 32'd0);
        chk("midrst_resp_valid", {31'd0, bus.o_resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        txn(1'b0, 2'd0, 1'b1, 32'h4FF, 32'h0, 32'h7F000000, 0);

        for (int t = 0; t < 250; t++) begin
            k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 4));
            a = $urandom;
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a, $urandom, $urandom, k);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        repeat (5) idle_cycle();
        chk("sram_queue_drained", sq.size(), 32'd0);
        chk("resp_queue_drained", rq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
